instr_state_sequencer: RTL and testbench

- Generates the StateID sequence that drives the multicycle controller's per-state mux and enable decode.
- Decodes the latched instruction word (IITB-RISC 16-bit ISA) and steps through fetch, decode, execute, memory and writeback states.
- Stalls on memory handshakes, evaluates conditional-write and branch conditions, and iterates LM/SM register lists.
- Sits between the IR/flag/datapath status and the controller.

---
 rtl/instr_state_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_instr_state_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_state_sequencer.sv
// ---------------------------------------------------------------------------
// instr_state_sequencer
//
// Produces the StateID sequence for the IITB-RISC multicycle controller.
// Once the instruction word is latched, the sequencer decodes it and steps
// through the states that instruction needs: fetch, decode, execute, memory
// and writeback. It stalls on memory handshakes, resolves conditional-write
// and branch outcomes, and walks LM/SM register lists one register per
// memory transfer.
//
// Parameters
//   SW          width of o_state_id
//   LIST_W      width of the LM/SM register list taken from IR[LIST_W-1:0]
//
// Ports
//   i_clk          system clock, rising edge active
//   i_reset        synchronous, active-high reset
//   i_ir           instruction register contents, valid from DECODE onward
//   i_mem_ready    memory finished the current read/write this cycle
//   i_carry_flag   architectural C flag
//   i_zero_flag    architectural Z flag
//   i_eq           datapath compare result, regA == regB
//   o_state_id     registered current state, consumed by the controller
//   o_ir_load      capture memory data into IR (combinational)
//   o_reg_index    LM/SM register currently being transferred (registered)
//   o_instr_done   last cycle of the current instruction (combinational)
//   o_illegal      undefined opcode or cz field seen in DECODE (combinational)
// ---------------------------------------------------------------------------
module instr_state_sequencer #(
    parameter int SW     = 5,
    parameter int LIST_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [15:0]               i_ir,
    input  logic                      i_mem_ready,
    input  logic                      i_carry_flag,
    input  logic                      i_zero_flag,
    input  logic                      i_eq,
    output logic [SW-1:0]             o_state_id,
    output logic                      o_ir_load,
    output logic [$clog2(LIST_W)-1:0] o_reg_index,
    output logic                      o_instr_done,
    output logic                      o_illegal
);

    localparam int IDX_W = $clog2(LIST_W);

    // State codes are shared with the controller's decode tables, so the
    // numeric values are fixed and must not be reordered.
    localparam logic [SW-1:0] S_FETCH    = SW'(0);
    localparam logic [SW-1:0] S_DECODE   = SW'(1);
    localparam logic [SW-1:0] S_R_EX     = SW'(2);
    localparam logic [SW-1:0] S_R_WB     = SW'(3);
    localparam logic [SW-1:0] S_ADI_EX   = SW'(4);
    localparam logic [SW-1:0] S_ADI_WB   = SW'(5);
    localparam logic [SW-1:0] S_LHI_WB   = SW'(6);
    localparam logic [SW-1:0] S_MEM_ADDR = SW'(7);
    localparam logic [SW-1:0] S_LW_RD    = SW'(8);
    localparam logic [SW-1:0] S_LW_WB    = SW'(9);
    localparam logic [SW-1:0] S_SW_WR    = SW'(10);
    localparam logic [SW-1:0] S_BEQ_CMP  = SW'(11);
    localparam logic [SW-1:0] S_BEQ_TAKE = SW'(12);
    localparam logic [SW-1:0] S_JAL      = SW'(13);
    localparam logic [SW-1:0] S_JLR      = SW'(14);
    localparam logic [SW-1:0] S_LM_STEP  = SW'(15);
    localparam logic [SW-1:0] S_SM_STEP  = SW'(16);

    // Opcodes in IR[15:12]
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    logic [SW-1:0]     r_state;
    logic [LIST_W-1:0] r_mask;
    logic [IDX_W-1:0]  r_reg_index;

    logic [SW-1:0]     w_next_state;
    logic [LIST_W-1:0] w_next_mask;
    logic [IDX_W-1:0]  w_next_index;
    logic [3:0]        w_opcode;
    logic [1:0]        w_cz;
    logic [LIST_W-1:0] w_list;
    logic [LIST_W-1:0] w_list_cleared;
    logic              w_unused_ir;

    assign w_opcode = i_ir[15:12];
    assign w_cz     = i_ir[1:0];
    assign w_list   = i_ir[LIST_W-1:0];

    // Remaining list once the register being transferred now is done.
    assign w_list_cleared = r_mask & ~(LIST_W'(1) << r_reg_index);

    // The register-field bits are decoded by the controller, not here.
    assign w_unused_ir = ^i_ir[11:8];

    // Priority encoder returning the lowest set bit; an empty mask yields 0.
    // Scanning downward lets the lowest set bit be the last one written.
    function automatic logic [IDX_W-1:0] lowest_set_bit(input logic [LIST_W-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Next-state, list bookkeeping and the combinational strobes. Every
    // state holds by default, so stalls only need to leave things alone.
    // The R-type cz field and the LW/SW choice are re-read from IR in the
    // later states because IR stays stable for the whole instruction.
    always_comb begin
        w_next_state = r_state;
        w_next_mask  = r_mask;
        w_next_index = r_reg_index;
        o_ir_load    = 1'b0;
        o_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (i_mem_ready) begin
                    o_ir_load    = 1'b1;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_NDU: begin
                        if (w_cz == 2'b11) begin
                            o_illegal    = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_R_EX;
                        end
                    end
                    OP_ADI:        w_next_state = S_ADI_EX;
                    OP_LHI:        w_next_state = S_LHI_WB;
                    OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
                    OP_LM, OP_SM: begin
                        w_next_mask  = w_list;
                        w_next_index = lowest_set_bit(w_list);
                        if (w_list == '0) begin
                            w_next_state = S_FETCH;
                        end else if (w_opcode == OP_LM) begin
                            w_next_state = S_LM_STEP;
                        end else begin
                            w_next_state = S_SM_STEP;
                        end
                    end
                    OP_BEQ:        w_next_state = S_BEQ_CMP;
                    OP_JAL:        w_next_state = S_JAL;
                    OP_JLR:        w_next_state = S_JLR;
                    default: begin
                        o_illegal    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_R_EX: begin
                case (w_cz)
                    2'b00:   w_next_state = S_R_WB;
                    2'b10:   w_next_state = i_carry_flag ? S_R_WB : S_FETCH;
                    2'b01:   w_next_state = i_zero_flag  ? S_R_WB : S_FETCH;
                    default: w_next_state = S_FETCH;
                endcase
            end

            S_R_WB:     w_next_state = S_FETCH;
            S_ADI_EX:   w_next_state = S_ADI_WB;
            S_ADI_WB:   w_next_state = S_FETCH;
            S_LHI_WB:   w_next_state = S_FETCH;
            S_MEM_ADDR: w_next_state = (w_opcode == OP_SW) ? S_SW_WR : S_LW_RD;

            S_LW_RD: begin
                if (i_mem_ready) begin
                    w_next_state = S_LW_WB;
                end
            end

            S_LW_WB: w_next_state = S_FETCH;

            S_SW_WR: begin
                if (i_mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end

            S_BEQ_CMP:  w_next_state = i_eq ? S_BEQ_TAKE : S_FETCH;
            S_BEQ_TAKE: w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_FETCH;
            S_JLR:      w_next_state = S_FETCH;

            S_LM_STEP, S_SM_STEP: begin
                if (i_mem_ready) begin
                    w_next_mask = w_list_cleared;
                    if (w_list_cleared != '0) begin
                        w_next_index = lowest_set_bit(w_list_cleared);
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end

            default: w_next_state = S_FETCH;
        endcase
    end

    // An instruction finishes in whichever non-fetch cycle heads back to
    // FETCH; stalls keep the same state and therefore never flag it.
    assign o_instr_done = (r_state != S_FETCH) && (w_next_state == S_FETCH);

    // State and list registers. Reset wins over everything so an aborted
    // instruction leaves no half-walked register list behind.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_mask      <= '0;
            r_reg_index <= '0;
        end else begin
            r_state     <= w_next_state;
            r_mask      <= w_next_mask;
            r_reg_index <= w_next_index;
        end
    end

    assign o_state_id  = r_state;
    assign o_reg_index = r_reg_index;

endmodule

// File: tb/tb_instr_state_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_state_sequencer
//
// Drives instruction scenarios one cycle at a time. Each driven cycle pushes
// the outputs it should produce into a queue; a monitor on the falling edge
// pops each entry and compares it with the live outputs.
// ---------------------------------------------------------------------------
module tb_instr_state_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir;
    logic        memReady;
    logic        carryFlag;
    logic        zeroFlag;
    logic        eq;
    logic [4:0]  stateId;
    logic        irLoad;
    logic [2:0]  regIndex;
    logic        instrDone;
    logic        illegal;

    typedef struct packed {
        logic [4:0] st;
        logic       done;
        logic       ld;
        logic       ill;
        logic       chkIdx;
        logic [2:0] idx;
    } expect_t;

    expect_t expQ[$];
    int      total = 0;
    int      bad   = 0;
    int      stepNo = 0;

    localparam logic [4:0] FE = 5'd0,  DE = 5'd1,  REX = 5'd2,  RWB = 5'd3;
    localparam logic [4:0] AEX = 5'd4, AWB = 5'd5, LHI = 5'd6,  MAD = 5'd7;
    localparam logic [4:0] LRD = 5'd8, LWB = 5'd9, SWR = 5'd10, BCM = 5'd11;
    localparam logic [4:0] BTK = 5'd12, JAL = 5'd13, JLR = 5'd14;
    localparam logic [4:0] LMS = 5'd15, SMS = 5'd16;

    instr_state_sequencer #(.SW(5), .LIST_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_ir         (ir),
        .i_mem_ready  (memReady),
        .i_carry_flag (carryFlag),
        .i_zero_flag  (zeroFlag),
        .i_eq         (eq),
        .o_state_id   (stateId),
        .o_ir_load    (irLoad),
        .o_reg_index  (regIndex),
        .o_instr_done (instrDone),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s step=%0d: got %0d, wanted %0d", tag, stepNo, observed, expected);
        end
    endtask

    // Drive one cycle of inputs (just after a rising edge) and queue what
    // the outputs should read before the next rising edge.
    task automatic applyStimulus(input logic rst, input logic mr, input logic [4:0] st,
                                 input logic done, input logic ld, input logic ill,
                                 input logic chk, input logic [2:0] idx);
        expect_t e;
        reset    = rst;
        memReady = mr;
        e.st = st; e.done = done; e.ld = ld; e.ill = ill; e.chkIdx = chk; e.idx = idx;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // FETCH with memory ready, then DECODE with the given outcome.
    task automatic fetchDecode(input logic [15:0] instr, input logic decDone, input logic decIll);
        ir = instr;
        applyStimulus(1'b0, 1'b1, FE, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, DE, decDone, 1'b0, decIll, 1'b0, 3'd0);
    endtask

    // Monitor: outputs are settled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            expect_t e;
            e = expQ.pop_front();
            stepNo++;
            checkOutput("state_id", 32'(stateId), 32'(e.st));
            checkOutput("instr_done", 32'(instrDone), 32'(e.done));
            checkOutput("ir_load", 32'(irLoad), 32'(e.ld));
            checkOutput("illegal", 32'(illegal), 32'(e.ill));
            if (e.chkIdx) begin
                checkOutput("reg_index", 32'(regIndex), 32'(e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; memReady = 1'b0; ir = 16'h0000;
        carryFlag = 1'b0; zeroFlag = 1'b0; eq = 1'b0;
        @(posedge clk);
        #1;

        // Two reset cycles: FETCH, list index cleared, no strobes.
        applyStimulus(1'b1, 1'b0, FE, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        applyStimulus(1'b1, 1'b0, FE, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        // FETCH holds while memory is not ready.
        applyStimulus(1'b0, 1'b0, FE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // ADI: 0,1,4,5
        fetchDecode(16'h1283, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, AEX, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, AWB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // ADC, carry clear: skipped write
        carryFlag = 1'b0;
        fetchDecode(16'h0042, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, REX, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        // ADC, carry set: writes back
        carryFlag = 1'b1;
        fetchDecode(16'h0042, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, REX, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, RWB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        carryFlag = 1'b0;
        // ADZ, zero set: writes back
        zeroFlag = 1'b1;
        fetchDecode(16'h0041, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, REX, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, RWB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        zeroFlag = 1'b0;
        // R-type with cz=11 is illegal in DECODE
        fetchDecode(16'h0003, 1'b1, 1'b1);

        // LW with a three-cycle memory stall
        fetchDecode(16'h4000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, MAD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, LRD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        end
        applyStimulus(1'b0, 1'b1, LRD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, LWB, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // SW with one stall cycle
        fetchDecode(16'h5000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, MAD, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, SWR, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, SWR, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // LM list 1010_0100: registers 2,5,7 with a stall on the first
        fetchDecode(16'h60A4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, LMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b0, 1'b1, LMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b0, 1'b1, LMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        applyStimulus(1'b0, 1'b1, LMS, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
        // LM with empty list finishes in DECODE
        fetchDecode(16'h6000, 1'b1, 1'b0);

        // BEQ taken and not taken
        eq = 1'b1;
        fetchDecode(16'hC000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, BCM, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, BTK, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        eq = 1'b0;
        fetchDecode(16'hC000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, BCM, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // LHI, JAL, JLR single-state instructions
        fetchDecode(16'h3000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, LHI, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        fetchDecode(16'h8000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, JAL, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        fetchDecode(16'h9000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, JLR, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // Undefined opcode
        fetchDecode(16'hF000, 1'b1, 1'b1);

        // SM interrupted by reset mid-list (reset beats mem_ready)
        fetchDecode(16'h70A4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, SMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b1, 1'b1, SMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        applyStimulus(1'b0, 1'b0, FE, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        // Same SM restarts from the lowest set bit
        fetchDecode(16'h70A4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, SMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b0, 1'b1, SMS, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        applyStimulus(1'b0, 1'b1, SMS, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
        applyStimulus(1'b0, 1'b0, FE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(negedge clk);
        end
        if (expQ.size() != 0) begin
            checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
